// File: rtl/mvm_pkg.sv
// -----------------------------------------------------------------------------
// mvm_pkg
// Shared definitions for the matrix-vector multiplier and its result drain:
//   drain_state_e : drain FSM state encoding (IDLE / DRAIN / HOLD)
//   mvm_res_w     : width of one dot product on the serial result chain,
//                   2*DW for the product plus $clog2(N) bits of accumulation growth
// -----------------------------------------------------------------------------
package mvm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } drain_state_e;

    function automatic int mvm_res_w(input int n, input int dw);
        return (32'sd2 * dw) + $clog2(n);
    endfunction

endpackage

// File: rtl/mvm_result_drain_if.sv
// -----------------------------------------------------------------------------
// mvm_result_drain_if
// Bundles the drain's chain-side and vector-side signals.
//   comp_done  : multiplier -> drain, 1-cycle "dot products final" pulse
//   result_in  : multiplier chain head, RW bits
//   shift_en   : drain -> multiplier, chain shift command
//   out_vec    : N elements of OW bits, element i at [i*OW +: OW]
//   out_valid  : out_vec holds a complete vector
//   out_ready  : downstream accepts on out_valid && out_ready
//   busy       : drain is in DRAIN or HOLD
//   overrun    : sticky, a comp_done was dropped
// modport master : the drain itself
// modport slave  : the multiplier/downstream environment
// -----------------------------------------------------------------------------
interface mvm_result_drain_if #(
    parameter int N  = 3,
    parameter int DW = 8,
    parameter int OW = 32'sd2 * DW
);
    import mvm_pkg::*;

    localparam int RW = mvm_res_w(N, DW);

    logic              comp_done;
    logic [RW-1:0]     result_in;
    logic              shift_en;
    logic [N*OW-1:0]   out_vec;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              overrun;

    modport master (
        input  comp_done, result_in, out_ready,
        output shift_en, out_vec, out_valid, busy, overrun
    );

    modport slave (
        output comp_done, result_in, out_ready,
        input  shift_en, out_vec, out_valid, busy, overrun
    );

endinterface

// File: rtl/mvm_sat_trunc.sv
// -----------------------------------------------------------------------------
// mvm_sat_trunc
// Narrows one unsigned chain element from RW to OW bits.
//   din  : RW-bit unsigned element from the chain
//   dout : OW-bit element for the output vector
// Build option MVM_DRAIN_SAT_EN: when defined, any set bit above OW-1 clamps the
// element to all-ones; when undefined, the high bits are dropped. With OW == RW
// the element passes through unchanged in both builds.
// -----------------------------------------------------------------------------
module mvm_sat_trunc #(
    parameter int RW = 18,
    parameter int OW = 16
) (
    input  logic [RW-1:0] din,
    output logic [OW-1:0] dout
);

    generate
        if (OW < RW) begin : g_narrow
`ifdef MVM_DRAIN_SAT_EN
            // Unsigned clamp: any overflow bit forces the maximum OW-bit value.
            always_comb begin
                if (|din[RW-1:OW]) begin
                    dout = {OW{1'b1}};
                end else begin
                    dout = din[OW-1:0];
                end
            end
`else
            // High bits are intentionally discarded in the truncating build.
            logic unused_hi_s;
            assign unused_hi_s = ^din[RW-1:OW];

            // Plain truncation to the low OW bits.
            always_comb begin
                dout = din[OW-1:0];
            end
`endif
        end else begin : g_pass
            // Element already fits: pass straight through.
            always_comb begin
                dout = din;
            end
        end
    endgenerate

endmodule

// File: rtl/mvm_result_drain.sv
// -----------------------------------------------------------------------------
// mvm_result_drain
// Unloads the multiplier's serial result chain after a compute-done pulse,
// deserialises the N dot products into a vector buffer and offers the vector
// on a valid/ready port.
// Ports:
//   clk  : clock, all state on posedge
//   rst  : asynchronous active-low reset; abandons any partial vector
//   bus  : mvm_result_drain_if.master (comp_done, result_in, shift_en,
//          out_vec, out_valid, out_ready, busy, overrun)
// Build option MVM_DRAIN_SAT_EN selects saturation instead of truncation when
// narrowing elements (see mvm_sat_trunc).
// shift_en is a combinational decode of the registered count so the chain
// shifts in the same cycle the current head element is captured.
// -----------------------------------------------------------------------------
module mvm_result_drain
    import mvm_pkg::*;
#(
    parameter int N  = 3,
    parameter int DW = 8,
    parameter int OW = 32'sd2 * DW
) (
    input  logic               clk,
    input  logic               rst,
    mvm_result_drain_if.master bus
);

    localparam int            RW   = mvm_res_w(N, DW);
    localparam int            CW   = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 32'sd1);

    drain_state_e    state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [OW-1:0]   buf_q [N];
    logic [OW-1:0]   buf_d [N];
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;
    logic            overrun_q, overrun_d;
    logic [OW-1:0]   elem_s;
    logic            shift_en_s;
    logic [N*OW-1:0] out_vec_s;

    mvm_sat_trunc #(
        .RW (RW),
        .OW (OW)
    ) u_sat_trunc (
        .din  (bus.result_in),
        .dout (elem_s)
    );

    // Next-state, capture and chain-shift decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        overrun_d  = overrun_q;
        shift_en_s = 1'b0;
        for (int i = 0; i < N; i++) begin
            buf_d[i] = buf_q[i];
        end

        case (state_q)
            IDLE: begin
                if (bus.comp_done) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end

            DRAIN: begin
                // The last element is already at the chain head: no further shift.
                shift_en_s = (cnt_q != LAST);
                for (int i = 0; i < N; i++) begin
                    if (cnt_q == CW'(i)) begin
                        buf_d[i] = elem_s;
                    end else begin
                        buf_d[i] = buf_q[i];
                    end
                end
                cnt_d = cnt_q + CW'(1'b1);
                if (bus.comp_done) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
                if (cnt_q == LAST) begin
                    state_d = HOLD;
                end else begin
                    state_d = DRAIN;
                end
            end

            HOLD: begin
                if (bus.out_ready) begin
                    // Accepting the vector frees the buffer, so a coincident
                    // comp_done starts the next drain without a bubble.
                    if (bus.comp_done) begin
                        state_d = DRAIN;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = HOLD;
                    if (bus.comp_done) begin
                        overrun_d = 1'b1;
                    end else begin
                        overrun_d = overrun_q;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        out_valid_d = (state_d == HOLD);
        busy_d      = (state_d != IDLE);
    end

    // State, counter, buffer and status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            for (int i = 0; i < N; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

    // Flatten the buffer into the output vector, element i at [i*OW +: OW].
    always_comb begin
        out_vec_s = '0;
        for (int i = 0; i < N; i++) begin
            out_vec_s[i*OW +: OW] = buf_q[i];
        end
    end

    assign bus.shift_en  = shift_en_s;
    assign bus.out_vec   = out_vec_s;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.overrun   = overrun_q;

endmodule
